// File: rtl/fwrisc_mds_pkg.sv
// Shared op encoding, op classification helpers and issuer state type for the
// multiply/divide/shift unit front end.
package fwrisc_mds_pkg;

  localparam logic [3:0] OP_SLL    = 4'd0;
  localparam logic [3:0] OP_SRL    = 4'd1;
  localparam logic [3:0] OP_SRA    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_MULH   = 4'd4;
  localparam logic [3:0] OP_MULHSU = 4'd5;
  localparam logic [3:0] OP_MULHU  = 4'd6;
  localparam logic [3:0] OP_DIV    = 4'd7;
  localparam logic [3:0] OP_DIVU   = 4'd8;
  localparam logic [3:0] OP_REM    = 4'd9;
  localparam logic [3:0] OP_REMU   = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } mds_issuer_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_REMU;
  endfunction

endpackage

// File: rtl/fwrisc_mds_issuer.sv
// Initiator-side controller for fwrisc_mul_div_shift: one op in flight, with
// local rejection of illegal/disabled ops, a WAIT timeout and spurious-result flag.
module fwrisc_mds_issuer
  import fwrisc_mds_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          ENABLE_MUL     = 1'b1,
  parameter bit          ENABLE_DIV     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  output logic [31:0] mds_in_a,
  output logic [31:0] mds_in_b,
  output logic [3:0]  mds_op,
  output logic        mds_in_valid,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        spurious_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mds_issuer_state_e state_q;
  logic [7:0]        cnt_q;
  logic              op_enabled;

  always_comb begin
    op_enabled = is_legal_op(req_op)
              && (ENABLE_MUL || !is_mul_op(req_op))
              && (ENABLE_DIV || !is_div_op(req_op));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready    <= 1'b1;
      mds_in_valid <= 1'b0;
      mds_in_a     <= '0;
      mds_in_b     <= '0;
      mds_op       <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_rd       <= '0;
      rsp_err      <= 1'b0;
      spurious_err <= 1'b0;
    end else begin
      mds_in_valid <= 1'b0;
      if (mds_out_valid && (state_q != ST_WAIT)) begin
        spurious_err <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_rd    <= req_rd;
            if (op_enabled) begin
              // Operand registers double as the request latch and stay put until RESP.
              mds_in_a     <= req_a;
              mds_in_b     <= req_b;
              mds_op       <= req_op;
              mds_in_valid <= 1'b1;
              state_q      <= ST_ISSUE;
            end else begin
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state_q   <= ST_RESP;
            end
          end
        end

        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // A result arriving on the last allowed cycle takes priority over the timeout.
          if (mds_out_valid) begin
            rsp_data  <= mds_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_mds_issuer.sv
// Self-checking bench for fwrisc_mds_issuer: random ops against an arithmetic
// reference of the unit, plus directed timeout, reject, reset and back-pressure cases.
module tb_fwrisc_mds_issuer;
  import fwrisc_mds_pkg::*;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [31:0] mds_out = '0;
  logic        mds_out_valid = 1'b0;
  logic        rsp_ready = 1'b0;

  logic        req_ready, mds_in_valid, rsp_valid, rsp_err, spurious_err;
  logic [31:0] mds_in_a, mds_in_b, rsp_data;
  logic [3:0]  mds_op;
  logic [4:0]  rsp_rd;

  logic        nd_req_valid = 1'b0;
  logic        nd_rsp_ready = 1'b0;
  logic        nd_req_ready, nd_mds_in_valid, nd_rsp_valid, nd_rsp_err, nd_spurious_err;
  logic [31:0] nd_mds_in_a, nd_mds_in_b, nd_rsp_data;
  logic [3:0]  nd_mds_op;
  logic [4:0]  nd_rsp_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fwrisc_mds_issuer #(.TIMEOUT_CYCLES(TMO), .ENABLE_MUL(1'b1), .ENABLE_DIV(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_rd(req_rd),
    .mds_in_a(mds_in_a), .mds_in_b(mds_in_b), .mds_op(mds_op), .mds_in_valid(mds_in_valid),
    .mds_out(mds_out), .mds_out_valid(mds_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .spurious_err(spurious_err)
  );

  fwrisc_mds_issuer #(.TIMEOUT_CYCLES(64), .ENABLE_MUL(1'b1), .ENABLE_DIV(1'b0)) dut_nd (
    .clock(clock), .reset(reset),
    .req_valid(nd_req_valid), .req_ready(nd_req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_rd(req_rd),
    .mds_in_a(nd_mds_in_a), .mds_in_b(nd_mds_in_b), .mds_op(nd_mds_op),
    .mds_in_valid(nd_mds_in_valid),
    .mds_out(32'h0), .mds_out_valid(1'b0),
    .rsp_valid(nd_rsp_valid), .rsp_ready(nd_rsp_ready), .rsp_data(nd_rsp_data),
    .rsp_rd(nd_rsp_rd), .rsp_err(nd_rsp_err), .spurious_err(nd_spurious_err)
  );

  // RISC-V M-extension / base shift semantics, including divide-by-zero and overflow.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    case (op)
      OP_SLL:    return a << b[4:0];
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    return $unsigned($signed(a) >>> b[4:0]);
      OP_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      OP_MULH:   begin p = ea * eb;                 return p[63:32]; end
      OP_MULHSU: begin p = ea * {32'h0, b};         return p[63:32]; end
      OP_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $unsigned($signed(a) / $signed(b));
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : $unsigned($signed(a) % $signed(b));
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  // Runs one request on dut; lat = unit latency in cycles (0 = never answers),
  // hold = cycles rsp_ready stays low once the response is visible.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [4:0] rd, input int lat, input int hold, input string tag);
    logic        legal, tmo, exp_err;
    logic [31:0] exp_data;
    int          exp_edges, edges;
    legal     = (op <= OP_REMU);
    tmo       = legal && ((lat == 0) || (lat > TMO));
    exp_err   = !legal || tmo;
    exp_data  = exp_err ? 32'h0 : ref_result(op, a, b);
    exp_edges = !legal ? 0 : (tmo ? 1 + TMO : 1 + lat);

    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_rd = rd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 4'($urandom); req_rd = 5'($urandom);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges <= 2 * TMO + 4) begin
      n_checks++;
      if (mds_in_valid !== (legal && edges == 0) || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s issue_pulse@%0d: in_valid=%b req_ready=%b want in_valid=%b req_ready=0",
                 tag, edges, mds_in_valid, req_ready, legal && edges == 0);
      end
      if (legal) begin
        n_checks++;
        if (mds_in_a !== a || mds_in_b !== b || mds_op !== op) begin
          n_fail++;
          $display("FAIL %s operands@%0d: got a=%h b=%h op=%0d want a=%h b=%h op=%0d",
                   tag, edges, mds_in_a, mds_in_b, mds_op, a, b, op);
        end
      end
      mds_out_valid = legal && (lat != 0) && (edges == lat);
      mds_out = mds_out_valid ? ref_result(mds_op, mds_in_a, mds_in_b) : $urandom;
      @(posedge clock); #1;
      mds_out_valid = 1'b0;
      edges++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || edges != exp_edges) begin
      n_fail++;
      $display("FAIL %s rsp_latency: got valid=%b after %0d edges want valid=1 after %0d",
               tag, rsp_valid, edges, exp_edges);
    end
    for (int i = 0; i <= hold; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_rd !== rd || rsp_err !== exp_err ||
          req_ready !== 1'b0 || mds_in_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s rsp_fields@%0d: got v=%b data=%h rd=%0d err=%b rr=%b want v=1 data=%h rd=%0d err=%b rr=0",
                 tag, i, rsp_valid, rsp_data, rsp_rd, rsp_err, req_ready, exp_data, rd, exp_err);
      end
      if (i == hold) rsp_ready = 1'b1;
      @(posedge clock); #1;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got rsp_valid=%b req_ready=%b want 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    n_checks++;
    if ({req_ready, mds_in_valid, mds_in_a, mds_in_b, mds_op, rsp_valid, rsp_data, rsp_rd, rsp_err, spurious_err}
        !== {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got rr=%b iv=%b a=%h b=%h op=%h rv=%b d=%h rd=%h e=%b sp=%b want 1,0,0...",
               req_ready, mds_in_valid, mds_in_a, mds_in_b, mds_op, rsp_valid, rsp_data, rsp_rd, rsp_err, spurious_err);
    end
    n_checks++;
    if ({nd_req_ready, nd_rsp_valid, nd_spurious_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_values_nd: got rr=%b rv=%b sp=%b want 1,0,0", nd_req_ready, nd_rsp_valid, nd_spurious_err);
    end
  endtask

  task automatic test_mul();
    run_op(32'd7, 32'd6, OP_MUL, 5'd5, 3, 0, "mul_7x6");
    n_checks++;
    if (ref_result(OP_MUL, 32'd7, 32'd6) !== 32'd42) begin
      n_fail++; $display("FAIL mul_ref: got %0d want 42", ref_result(OP_MUL, 32'd7, 32'd6));
    end
  endtask

  task automatic test_illegal();
    run_op(32'h1111_2222, 32'h3333_4444, 4'd12, 5'd9, 2, 1, "illegal_op12");
    run_op(32'h5, 32'h6, 4'd15, 5'd31, 2, 0, "illegal_op15");
  endtask

  task automatic test_disabled_div();
    logic [3:0] ops[2];
    ops[0] = OP_DIV; ops[1] = OP_REMU;
    for (int k = 0; k < 2; k++) begin
      nd_req_valid = 1'b1; req_op = ops[k]; req_rd = 5'd9; req_a = 32'd100; req_b = 32'd7;
      @(posedge clock); #1;
      nd_req_valid = 1'b0;
      n_checks++;
      if (nd_rsp_valid !== 1'b1 || nd_rsp_err !== 1'b1 || nd_rsp_data !== 32'h0 ||
          nd_rsp_rd !== 5'd9 || nd_mds_in_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL nodiv_reject op=%0d: got v=%b e=%b d=%h rd=%0d iv=%b want 1,1,0,9,0",
                 ops[k], nd_rsp_valid, nd_rsp_err, nd_rsp_data, nd_rsp_rd, nd_mds_in_valid);
      end
      nd_rsp_ready = 1'b1;
      @(posedge clock); #1;
      nd_rsp_ready = 1'b0;
      n_checks++;
      if (nd_rsp_valid !== 1'b0 || nd_req_ready !== 1'b1 || nd_mds_in_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL nodiv_idle op=%0d: got v=%b rr=%b iv=%b want 0,1,0",
                 ops[k], nd_rsp_valid, nd_req_ready, nd_mds_in_valid);
      end
    end
  endtask

  task automatic test_timeout_spurious();
    run_op(32'd3, 32'd4, OP_MULHU, 5'd12, 0, 0, "timeout");
    n_checks++;
    if (spurious_err !== 1'b0) begin
      n_fail++; $display("FAIL spurious_before: got %b want 0", spurious_err);
    end
    mds_out_valid = 1'b1; mds_out = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    mds_out_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (spurious_err !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL spurious_late@%0d: got sp=%b rv=%b rr=%b want 1,0,1", i, spurious_err, rsp_valid, req_ready);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_boundary();
    run_op(32'h1234, 32'd1, OP_MUL, 5'd17, TMO, 0, "coincident_limit");
    run_op(32'h1234, 32'd1, OP_MUL, 5'd18, TMO + 1, 0, "one_past_limit");
  endtask

  task automatic test_backpressure();
    run_op(32'h8000_0000, 32'd4, OP_SRA, 5'd3, 2, 10, "sra_backpressure");
    n_checks++;
    if (ref_result(OP_SRA, 32'h8000_0000, 32'd4) !== 32'hF800_0000) begin
      n_fail++; $display("FAIL sra_ref: got %h want f8000000", ref_result(OP_SRA, 32'h8000_0000, 32'd4));
    end
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_a = 32'd9; req_b = 32'd3; req_op = OP_DIVU; req_rd = 5'd4;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if ({req_ready, mds_in_valid, mds_in_a, mds_in_b, mds_op, rsp_valid, rsp_data, rsp_rd, rsp_err, spurious_err}
        !== {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_in_wait: got rr=%b iv=%b a=%h b=%h op=%h rv=%b d=%h rd=%h e=%b sp=%b want 1,0,0...",
               req_ready, mds_in_valid, mds_in_a, mds_in_b, mds_op, rsp_valid, rsp_data, rsp_rd, rsp_err, spurious_err);
    end
    for (int i = 0; i < 2 * TMO; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL no_rsp_after_reset@%0d: got %b want 0", i, rsp_valid);
      end
    end
    run_op(32'd100, 32'd7, OP_REM, 5'd8, 1, 0, "after_reset");
  endtask

  task automatic test_random();
    int r, lat;
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : (r % TMO) + 1;
      run_op($urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, 4'($urandom_range(0, 15)),
             5'($urandom), lat, $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 4'(i), 5'(i), 1, 0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_illegal();
    test_disabled_div();
    test_boundary();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_timeout_spurious();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
